// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues in-order word requests at the current PC, buffers
// returned instructions with their PCs, and flushes on control-flow redirects.
module fetch_stage #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Counters and pointers
    logic [CW-1:0] inflight_reg, inflight_next;
    logic [CW-1:0] drop_reg, drop_next;
    logic [CW-1:0] count_reg, count_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] aw_ptr_reg, aw_ptr_next;
    logic [PW-1:0] ar_ptr_reg, ar_ptr_next;
    logic          fault_reg, fault_next;

    // Storage: instruction buffer {pc, instr} and PCs of accepted requests
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [31:0] addr_mem  [DEPTH];

    logic          pc_aligned;
    logic [CW:0]   occupancy;
    logic          credit_ok;
    logic          req_valid_int;
    logic          accept;
    logic          rsp_keep;
    logic          if_valid_int;
    logic          deq;

    assign pc_aligned    = (pc[1:0] == 2'b00);
    assign occupancy     = {1'b0, inflight_reg} + {1'b0, count_reg};
    assign credit_ok     = (occupancy < (CW+1)'(DEPTH));
    // rst_n gates the request so nothing is offered while the memory is held in reset
    assign req_valid_int = rst_n && !redirect && !fault_reg && pc_aligned && credit_ok;
    assign accept        = req_valid_int && imem_req_ready;
    // A response arriving with a redirect belongs to the old stream and is discarded
    assign rsp_keep      = imem_rsp_valid && (drop_reg == '0) && !redirect;
    assign if_valid_int  = (count_reg != '0) && !redirect;
    assign deq           = if_valid_int && if_ready;

    assign imem_req_valid = req_valid_int;
    assign imem_req_addr  = pc;
    assign if_valid       = if_valid_int;
    assign if_instr       = instr_mem[rd_ptr_reg];
    assign if_pc          = pc_mem[rd_ptr_reg];
    assign fetch_fault    = fault_reg;

    always_comb begin
        next_pc = pc;
        if (rst_n) begin
            if (redirect) begin
                next_pc = redirect_target;
            end else if (accept) begin
                next_pc = pc + 32'd4;
            end
        end
    end

    always_comb begin
        inflight_next = inflight_reg;
        case ({accept, imem_rsp_valid})
            2'b10:   inflight_next = inflight_reg + CW'(1);
            2'b01:   inflight_next = inflight_reg - CW'(1);
            default: inflight_next = inflight_reg;
        endcase
    end

    always_comb begin
        drop_next = drop_reg;
        if (redirect) begin
            drop_next = inflight_reg - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_reg != '0)) begin
            drop_next = drop_reg - CW'(1);
        end
    end

    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (rsp_keep) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (redirect) begin
            count_next  = '0;
            rd_ptr_next = wr_ptr_reg;
        end else begin
            if (deq) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({rsp_keep, deq})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Address FIFO drains with every response, dropped or kept
    always_comb begin
        aw_ptr_next = aw_ptr_reg;
        ar_ptr_next = ar_ptr_reg;
        if (accept) begin
            aw_ptr_next = aw_ptr_reg + PW'(1);
        end
        if (imem_rsp_valid) begin
            ar_ptr_next = ar_ptr_reg + PW'(1);
        end
    end

    always_comb begin
        fault_next = fault_reg;
        if (redirect) begin
            fault_next = 1'b0;
        end else if (!pc_aligned) begin
            fault_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg <= '0;
            drop_reg     <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            aw_ptr_reg   <= '0;
            ar_ptr_reg   <= '0;
            fault_reg    <= (RESET_PC[1:0] != 2'b00);
        end else begin
            inflight_reg <= inflight_next;
            drop_reg     <= drop_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            aw_ptr_reg   <= aw_ptr_next;
            ar_ptr_reg   <= ar_ptr_next;
            fault_reg    <= fault_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_mem[aw_ptr_reg] <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            pc_mem[wr_ptr_reg]    <= addr_mem[ar_ptr_reg];
            instr_mem[wr_ptr_reg] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: drives a PC register and a fixed-latency memory model,
// logs accepts and decode handshakes, and checks them against hand-computed values.
module tb_fetch_stage;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] K        = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    typedef struct {logic [31:0] addr; int due;} mem_t;
    typedef struct {logic [31:0] pc; logic [31:0] instr; int cyc;} dq_t;
    typedef struct {logic [31:0] addr; int cyc;} acc_t;

    mem_t memq[$];
    dq_t  dq_log[$];
    acc_t acc_log[$];
    mem_t m_tmp;
    dq_t  d_tmp;
    acc_t a_tmp;

    int cyc = 0;
    int lat = 1;
    int vectors = 0;
    int miscompares = 0;

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc              (pc),
        .next_pc         (next_pc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Program counter register with no enable
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= RESET_PC;
        else        pc <= next_pc;
    end

    // Sample handshakes just before the rising edge
    always @(negedge clk) begin
        #4;
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) begin
                m_tmp.addr = imem_req_addr;
                m_tmp.due  = cyc + lat;
                memq.push_back(m_tmp);
                a_tmp.addr = imem_req_addr;
                a_tmp.cyc  = cyc;
                acc_log.push_back(a_tmp);
            end
            if (if_valid && if_ready) begin
                d_tmp.pc    = if_pc;
                d_tmp.instr = if_instr;
                d_tmp.cyc   = cyc;
                dq_log.push_back(d_tmp);
            end
        end
    end

    // Fixed-latency, in-order memory; returns addr ^ K
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end else if (memq.size() > 0 && memq[0].due == cyc + 1) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= memq[0].addr ^ K;
            memq.delete(0);
        end else begin
            imem_rsp_valid <= 1'b0;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect = 1'b0;
        if_ready = 1'b0;
        repeat (2) @(negedge clk);
        acc_log.delete();
        dq_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_dq(input int n, input string name, output bit ok);
        int budget;
        budget = 60;
        while (dq_log.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        ok = (dq_log.size() >= n);
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got %0d dequeues, expected %0d", name, dq_log.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
        vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
        vectors++; if (next_pc !== RESET_PC) begin miscompares++; $display("FAIL reset_next_pc: got %h expected %h", next_pc, RESET_PC); end
        $display("test_reset done: req_valid=%b if_valid=%b next_pc=%h", imem_req_valid, if_valid, next_pc);
    endtask

    task automatic test_stream();
        bit ok;
        lat = 1;
        apply_reset();
        if_ready = 1'b1;
        wait_dq(8, "stream", ok);
        if (!ok) return;
        vectors++; if (acc_log[0].addr !== 32'h0) begin miscompares++; $display("FAIL stream_first_addr: got %h expected 0", acc_log[0].addr); end
        vectors++; if (dq_log[0].cyc !== acc_log[0].cyc + 2) begin miscompares++; $display("FAIL stream_latency: got %0d expected %0d", dq_log[0].cyc - acc_log[0].cyc, 2); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (dq_log[i].pc !== 32'(4 * i) || dq_log[i].instr !== (32'(4 * i) ^ K) || dq_log[i].cyc !== dq_log[0].cyc + i) begin
                miscompares++;
                $display("FAIL stream_%0d: got pc=%h instr=%h cyc+%0d expected pc=%h instr=%h cyc+%0d",
                         i, dq_log[i].pc, dq_log[i].instr, dq_log[i].cyc - dq_log[0].cyc, 32'(4 * i), 32'(4 * i) ^ K, i);
            end
        end
        $display("test_stream done: %0d instructions delivered", dq_log.size());
    endtask

    task automatic test_backpressure();
        bit ok;
        lat = 1;
        apply_reset();
        repeat (10) @(negedge clk);
        #1;
        vectors++; if (acc_log.size() !== 4) begin miscompares++; $display("FAIL bp_accepts: got %0d expected 4", acc_log.size()); end
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
        vectors++; if (next_pc !== 32'h10 || pc !== 32'h10) begin miscompares++; $display("FAIL bp_next_pc: got next_pc=%h pc=%h expected 10", next_pc, pc); end
        vectors++; if (dq_log.size() !== 0) begin miscompares++; $display("FAIL bp_no_dequeue: got %0d expected 0", dq_log.size()); end
        @(negedge clk);
        if_ready = 1'b1;
        wait_dq(6, "bp", ok);
        if (!ok) return;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (dq_log[i].pc !== 32'(4 * i) || dq_log[i].instr !== (32'(4 * i) ^ K)) begin
                miscompares++;
                $display("FAIL bp_release_%0d: got pc=%h instr=%h expected pc=%h", i, dq_log[i].pc, dq_log[i].instr, 32'(4 * i));
            end
        end
        $display("test_backpressure done: %0d accepts before release", 4);
    endtask

    task automatic test_redirect_inflight();
        bit ok;
        int n_cyc;
        lat = 3;
        apply_reset();
        if_ready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (acc_log.size() !== 2) begin miscompares++; $display("FAIL rdi_outstanding: got %0d expected 2", acc_log.size()); end
        redirect = 1'b1;
        redirect_target = 32'h100;
        n_cyc = cyc;
        #1;
        vectors++; if (imem_req_valid !== 1'b0 || next_pc !== 32'h100) begin miscompares++; $display("FAIL rdi_redirect_cycle: got req_valid=%b next_pc=%h expected 0/100", imem_req_valid, next_pc); end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin miscompares++; $display("FAIL rdi_new_req: got valid=%b addr=%h expected 1/100", imem_req_valid, imem_req_addr); end
        wait_dq(2, "rdi", ok);
        if (!ok) return;
        vectors++; if (dq_log[0].pc !== 32'h100 || dq_log[0].instr !== (32'h100 ^ K)) begin miscompares++; $display("FAIL rdi_first: got pc=%h instr=%h expected pc=100", dq_log[0].pc, dq_log[0].instr); end
        vectors++; if (dq_log[1].pc !== 32'h104) begin miscompares++; $display("FAIL rdi_second: got pc=%h expected 104", dq_log[1].pc); end
        vectors++; if (dq_log[0].cyc !== n_cyc + 5) begin miscompares++; $display("FAIL rdi_latency: got N+%0d expected N+5", dq_log[0].cyc - n_cyc); end
        $display("test_redirect_inflight done: first new pc=%h", dq_log[0].pc);
    endtask

    task automatic test_redirect_coincident();
        bit ok;
        int n0;
        int n_cyc;
        lat = 1;
        apply_reset();
        if_ready = 1'b1;
        repeat (5) @(negedge clk);
        n0 = dq_log.size();
        redirect = 1'b1;
        redirect_target = 32'h300;
        n_cyc = cyc;
        #1;
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL rdc_if_valid: got %b expected 0", if_valid); end
        @(negedge clk);
        redirect = 1'b0;
        wait_dq(n0 + 3, "rdc", ok);
        if (!ok) return;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dq_log[n0 + i].pc !== 32'h300 + 32'(4 * i)) begin
                miscompares++;
                $display("FAIL rdc_pc_%0d: got %h expected %h", i, dq_log[n0 + i].pc, 32'h300 + 32'(4 * i));
            end
        end
        vectors++; if (dq_log[n0].cyc !== n_cyc + 3) begin miscompares++; $display("FAIL rdc_latency: got N+%0d expected N+3", dq_log[n0].cyc - n_cyc); end
        $display("test_redirect_coincident done: first new pc=%h", dq_log[n0].pc);
    endtask

    task automatic test_misaligned();
        bit ok;
        int n0;
        int n_acc;
        @(negedge clk);
        redirect = 1'b1;
        redirect_target = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        vectors++; if (imem_req_valid !== 1'b0 || next_pc !== 32'h102) begin miscompares++; $display("FAIL mis_first: got req_valid=%b next_pc=%h expected 0/102", imem_req_valid, next_pc); end
        @(negedge clk);
        #1;
        vectors++; if (fetch_fault !== 1'b1) begin miscompares++; $display("FAIL mis_fault_set: got %b expected 1", fetch_fault); end
        vectors++; if (imem_req_valid !== 1'b0 || next_pc !== 32'h102) begin miscompares++; $display("FAIL mis_hold: got req_valid=%b next_pc=%h expected 0/102", imem_req_valid, next_pc); end
        n_acc = acc_log.size();
        n0 = dq_log.size();
        repeat (4) @(negedge clk);
        #1;
        vectors++; if (acc_log.size() !== n_acc || fetch_fault !== 1'b1) begin miscompares++; $display("FAIL mis_sticky: got accepts+%0d fault=%b expected +0/1", acc_log.size() - n_acc, fetch_fault); end
        @(negedge clk);
        redirect = 1'b1;
        redirect_target = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL mis_fault_clear: got %b expected 0", fetch_fault); end
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin miscompares++; $display("FAIL mis_resume_req: got valid=%b addr=%h expected 1/200", imem_req_valid, imem_req_addr); end
        wait_dq(n0 + 2, "mis", ok);
        if (!ok) return;
        vectors++; if (dq_log[n0].pc !== 32'h200 || dq_log[n0 + 1].pc !== 32'h204) begin miscompares++; $display("FAIL mis_resume_pcs: got %h,%h expected 200,204", dq_log[n0].pc, dq_log[n0 + 1].pc); end
        $display("test_misaligned done: resumed at %h", dq_log[n0].pc);
    endtask

    task automatic test_wrap_async_reset();
        bit ok;
        int n0;
        @(negedge clk);
        n0 = dq_log.size();
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC || next_pc !== 32'h0) begin miscompares++; $display("FAIL wrap_next_pc: got valid=%b addr=%h next_pc=%h expected 1/fffffffc/0", imem_req_valid, imem_req_addr, next_pc); end
        wait_dq(n0 + 3, "wrap", ok);
        if (!ok) return;
        vectors++; if (dq_log[n0].pc !== 32'hFFFF_FFFC || dq_log[n0 + 1].pc !== 32'h0 || dq_log[n0 + 1].instr !== K) begin miscompares++; $display("FAIL wrap_pcs: got %h,%h instr=%h expected fffffffc,0 instr=%h", dq_log[n0].pc, dq_log[n0 + 1].pc, dq_log[n0 + 1].instr, K); end
        @(negedge clk);
        #1;
        vectors++; if (if_valid !== 1'b1 || imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_streaming: got if_valid=%b req_valid=%b expected 1/1", if_valid, imem_req_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset: got if_valid=%b req_valid=%b expected 0/0", if_valid, imem_req_valid); end
        vectors++; if (next_pc !== RESET_PC || fetch_fault !== 1'b0) begin miscompares++; $display("FAIL async_reset_pc: got next_pc=%h fault=%b expected %h/0", next_pc, fetch_fault, RESET_PC); end
        $display("test_wrap_async_reset done: if_valid=%b req_valid=%b after reset", if_valid, imem_req_valid);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_misaligned();
        test_wrap_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
